// File: rtl/boot_test_sequencer.sv
// Boot/test sequencer: streams a program into instruction memory, holds the CPU in
// reset for RST_HOLD cycles, then runs it until a tohost store or a cycle timeout.
// Optional feature macro BOOT_WDOG_KICK_EN: when defined, the timeout becomes a
// watchdog on store inactivity instead of an absolute RUN-cycle limit.
module boot_test_sequencer #(
  parameter int unsigned       ADDR_W      = 32,
  parameter int unsigned       DATA_W      = 32,
  parameter int unsigned       MAX_WORDS   = 256,
  parameter int unsigned       RST_HOLD    = 2,
  parameter int unsigned       TIMEOUT_CYC = 1000,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 32'h0000_0FFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  input  logic              dmem_we_mon,
  input  logic [ADDR_W-1:0] dmem_addr_mon,
  input  logic [DATA_W-1:0] dmem_wdata_mon,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic              load_err,
  output logic [DATA_W-1:0] fail_code,
  output logic [31:0]       cycle_count
);

  localparam int unsigned PtrW  = $clog2(MAX_WORDS);
  localparam int unsigned HoldW = $clog2(RST_HOLD + 1);

  localparam logic [PtrW-1:0]  LastIdx = PtrW'(MAX_WORDS - 1);
  localparam logic [HoldW-1:0] HoldEnd = HoldW'(RST_HOLD);
  localparam logic [31:0]      ToLast  = 32'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StDone} state_e;

  state_e           state_q;
  logic [PtrW-1:0]  ptr_q;
  logic [HoldW-1:0] hold_q;

  logic xfer;
  logic tohost_hit;
  logic expire;

  assign xfer       = ld_valid && ld_ready;
  assign tohost_hit = dmem_we_mon && (dmem_addr_mon == TOHOST_ADDR);

`ifdef BOOT_WDOG_KICK_EN
  // Cycles since the last store of any kind; any store kicks the watchdog.
  logic [31:0] idle_q;
  assign expire = !dmem_we_mon && (idle_q == ToLast);
`else
  assign expire = (cycle_count == ToLast);
`endif

  // Sequencer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      hold_q      <= '0;
      cpu_rst     <= 1'b1;
      ld_ready    <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      load_err    <= 1'b0;
      fail_code   <= '0;
      cycle_count <= '0;
`ifdef BOOT_WDOG_KICK_EN
      idle_q      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          cpu_rst <= 1'b1;
          if (start) begin
            state_q     <= StLoad;
            ptr_q       <= '0;
            ld_ready    <= 1'b1;
            done        <= 1'b0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
            load_err    <= 1'b0;
            fail_code   <= '0;
            cycle_count <= '0;
          end
        end
        StLoad: begin
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= ADDR_W'({ptr_q, 2'b00});
            imem_wdata <= ld_data;
            ptr_q      <= ptr_q + 1'b1;
            if (ld_last) begin
              state_q  <= StHold;
              ld_ready <= 1'b0;
              hold_q   <= '0;
            end else if (ptr_q == LastIdx) begin
              // Image overflows capacity: the final word is still written.
              state_q  <= StDone;
              ld_ready <= 1'b0;
              load_err <= 1'b1;
              done     <= 1'b1;
              pass     <= 1'b0;
            end
          end
        end
        StHold: begin
          // hold_q is 0 in the cycle carrying the last imem_we pulse, so cpu_rst
          // stays high for RST_HOLD full cycles after that pulse.
          if (hold_q == HoldEnd) begin
            state_q     <= StRun;
            cpu_rst     <= 1'b0;
            cycle_count <= '0;
`ifdef BOOT_WDOG_KICK_EN
            idle_q      <= '0;
`endif
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        StRun: begin
          if (tohost_hit) begin
            state_q   <= StDone;
            cpu_rst   <= 1'b1;
            done      <= 1'b1;
            fail_code <= dmem_wdata_mon;
            pass      <= (dmem_wdata_mon == DATA_W'(1));
          end else if (expire) begin
            state_q <= StDone;
            cpu_rst <= 1'b1;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
          end else begin
            if (cycle_count != '1) cycle_count <= cycle_count + 32'd1;
`ifdef BOOT_WDOG_KICK_EN
            idle_q <= dmem_we_mon ? '0 : idle_q + 32'd1;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_boot_test_sequencer.sv
// Self-checking bench for boot_test_sequencer: a table of RUN scenarios, an imem
// write scoreboard, plus hand-written overflow, reset-abort and ignored-start cases.
module tb_boot_test_sequencer;

  localparam int unsigned RstHold    = 2;
  localparam int unsigned TimeoutCyc = 1000;
  localparam int          NVec       = 7;

  typedef struct {
    int          st_cyc;   // RUN cycle of the single store, -1 for none
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        exp_pass;
    logic        exp_to;
    logic [31:0] exp_code;
    logic [31:0] exp_cnt;
  } run_vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk, rst, start, start_s;
  logic        ld_valid, ld_last;
  logic [31:0] ld_data;
  logic        dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;

  logic        ld_ready, imem_we, cpu_rst, done, pass, timeout, load_err;
  logic [31:0] imem_addr, imem_wdata, fail_code, cycle_count;

  logic        ld_ready_s, imem_we_s, cpu_rst_s, done_s, pass_s, timeout_s, load_err_s;
  logic [31:0] imem_addr_s, imem_wdata_s, fail_code_s, cycle_count_s;

  wr_t         exp_q[$];
  wr_t         exp_qs[$];
  int          n_vec, n_err;
  int          ptr_m, ptr_s, n_wr_s;
  bit          small_released;
  logic [31:0] prog[5];
  run_vec_t    vecs[NVec];

  boot_test_sequencer #(
    .RST_HOLD   (RstHold),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .cpu_rst       (cpu_rst),
    .dmem_we_mon   (dmem_we),
    .dmem_addr_mon (dmem_addr),
    .dmem_wdata_mon(dmem_wdata),
    .done          (done),
    .pass          (pass),
    .timeout       (timeout),
    .load_err      (load_err),
    .fail_code     (fail_code),
    .cycle_count   (cycle_count)
  );

  // Small-capacity instance for the overflow case; idles unless start_s pulses.
  boot_test_sequencer #(
    .MAX_WORDS  (4),
    .RST_HOLD   (RstHold),
    .TIMEOUT_CYC(TimeoutCyc)
  ) dut_small (
    .clk           (clk),
    .rst           (rst),
    .start         (start_s),
    .ld_valid      (ld_valid),
    .ld_ready      (ld_ready_s),
    .ld_data       (ld_data),
    .ld_last       (ld_last),
    .imem_we       (imem_we_s),
    .imem_addr     (imem_addr_s),
    .imem_wdata    (imem_wdata_s),
    .cpu_rst       (cpu_rst_s),
    .dmem_we_mon   (dmem_we),
    .dmem_addr_mon (dmem_addr),
    .dmem_wdata_mon(dmem_wdata),
    .done          (done_s),
    .pass          (pass_s),
    .timeout       (timeout_s),
    .load_err      (load_err_s),
    .fail_code     (fail_code_s),
    .cycle_count   (cycle_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got still running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // One clock: queue expected writes for handshakes, then score any imem writes.
  task automatic tick();
    wr_t e;
    if (ld_valid && ld_ready) begin
      exp_q.push_back('{addr: 32'(ptr_m * 4), data: ld_data});
      ptr_m++;
    end
    if (ld_valid && ld_ready_s) begin
      exp_qs.push_back('{addr: 32'(ptr_s * 4), data: ld_data});
      ptr_s++;
    end
    @(posedge clk);
    #1;
    if (!cpu_rst_s) small_released = 1'b1;
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        check("imem_we_unexpected", imem_addr, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("imem_addr", imem_addr, e.addr);
        check("imem_wdata", imem_wdata, e.data);
      end
    end
    if (imem_we_s) begin
      n_wr_s++;
      if (exp_qs.size() == 0) begin
        check("small_imem_we_unexpected", imem_addr_s, 32'hFFFF_FFFF);
      end else begin
        e = exp_qs.pop_front();
        check("small_imem_addr", imem_addr_s, e.addr);
        check("small_imem_wdata", imem_wdata_s, e.data);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_rst"}, cpu_rst, 1);
    check({tag, "_ld_ready"}, ld_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_load_err"}, load_err, 0);
    check({tag, "_fail_code"}, fail_code, 0);
    check({tag, "_cycle_count"}, cycle_count, 0);
  endtask

  task automatic pulse_start_main();
    start = 1'b1;
    ptr_m = 0;
    tick();
    start = 1'b0;
    check("start_ld_ready", ld_ready, 1);
    check("start_done_clr", done, 0);
    check("start_pass_clr", pass, 0);
    check("start_timeout_clr", timeout, 0);
    check("start_fail_code_clr", fail_code, 0);
    check("start_cycle_count_clr", cycle_count, 0);
    check("start_cpu_rst", cpu_rst, 1);
  endtask

  // Stream the program with ld_valid held high, then follow the reset hold into RUN.
  task automatic load_prog();
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_data  = prog[i];
      ld_last  = (i == 4);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    ld_data  = '0;
    check("load_last_pulse", imem_we, 1);
    check("load_ready_drop", ld_ready, 0);
    check("load_sb_drained", 32'(exp_q.size()), 0);
    for (int k = 1; k <= int'(RstHold); k++) begin
      tick();
      check("hold_cpu_rst", cpu_rst, 1);
      check("hold_imem_we", imem_we, 0);
    end
    tick();
    check("run_cpu_rst", cpu_rst, 0);
    check("run_first_count", cycle_count, 0);
  endtask

  task automatic run_until_done(input run_vec_t v);
    int c;
    c = 0;
    while (c < 1100 && !done) begin
      if (c == v.st_cyc) begin
        dmem_we    = 1'b1;
        dmem_addr  = v.st_addr;
        dmem_wdata = v.st_data;
      end
      tick();
      dmem_we    = 1'b0;
      dmem_addr  = '0;
      dmem_wdata = '0;
      c++;
    end
    check("end_done", done, 1);
    check("end_pass", pass, v.exp_pass);
    check("end_timeout", timeout, v.exp_to);
    check("end_fail_code", fail_code, v.exp_code);
    check("end_cycle_count", cycle_count, v.exp_cnt);
    check("end_cpu_rst", cpu_rst, 1);
    check("end_load_err", load_err, 0);
    repeat (3) tick();
    check("held_cycle_count", cycle_count, v.exp_cnt);
    check("held_done", done, 1);
    check("held_cpu_rst", cpu_rst, 1);
  endtask

  initial begin
    n_vec = 0; n_err = 0; ptr_m = 0; ptr_s = 0; n_wr_s = 0; small_released = 1'b0;
    rst = 1'b0; start = 1'b0; start_s = 1'b0;
    ld_valid = 1'b0; ld_last = 1'b0; ld_data = '0;
    dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;

    prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;
    prog[3] = 32'h7E30_2E23; prog[4] = 32'h0010_0F13;

    vecs[0] = '{40,  32'hFFC, 32'd1, 1'b1, 1'b0, 32'd1, 32'd40};
    vecs[1] = '{17,  32'hFFC, 32'd7, 1'b0, 1'b0, 32'd7, 32'd17};
    vecs[2] = '{-1,  32'h0,   32'd0, 1'b0, 1'b1, 32'd0, 32'd999};
    vecs[3] = '{999, 32'hFFC, 32'd1, 1'b1, 1'b0, 32'd1, 32'd999};
    vecs[4] = '{30,  32'h100, 32'd1, 1'b0, 1'b1, 32'd0, 32'd999};
    vecs[5] = '{0,   32'hFFC, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[6] = '{998, 32'hFFC, 32'd2, 1'b0, 1'b0, 32'd2, 32'd998};

    repeat (2) tick();
    check_reset_vals("reset");
    check("reset_small_cpu_rst", cpu_rst_s, 1);
    check("reset_small_ready", ld_ready_s, 0);
    rst = 1'b1;
    tick();
    check("idle_cpu_rst", cpu_rst, 1);
    check("idle_ld_ready", ld_ready, 0);

    // Each scenario starts from DONE of the previous one: the re-run path.
    for (int i = 0; i < NVec; i++) begin
      pulse_start_main();
      load_prog();
      run_until_done(vecs[i]);
    end

    // Overflow: capacity 4, six words streamed with no ld_last.
    start_s = 1'b1;
    ptr_s   = 0;
    tick();
    start_s = 1'b0;
    check("small_ld_ready", ld_ready_s, 1);
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'h0000_1000 + 32'(i);
      ld_last  = 1'b0;
      tick();
    end
    ld_valid = 1'b0;
    ld_data  = '0;
    check("small_ready_drop", ld_ready_s, 0);
    check("small_write_count", 32'(n_wr_s), 4);
    check("small_load_err", load_err_s, 1);
    check("small_done", done_s, 1);
    check("small_pass", pass_s, 0);
    check("small_timeout", timeout_s, 0);
    check("small_fail_code", fail_code_s, 0);
    check("small_cycle_count", cycle_count_s, 0);
    repeat (5) tick();
    check("small_cpu_never_released", 32'(small_released), 0);
    check("small_cpu_rst", cpu_rst_s, 1);

    // start ignored in RUN, then reset aborts mid-RUN.
    pulse_start_main();
    load_prog();
    repeat (10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_start_ignored_ready", ld_ready, 0);
    check("run_start_ignored_count", cycle_count, 11);
    check("run_start_ignored_cpu_rst", cpu_rst, 0);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check_reset_vals("midrun");
    rst = 1'b1;
    tick();
    check("post_reset_idle_cpu_rst", cpu_rst, 1);
    check("post_reset_idle_ready", ld_ready, 0);

    // Fresh run from IDLE after the abort.
    pulse_start_main();
    load_prog();
    run_until_done(vecs[0]);

    check("final_sb_empty", 32'(exp_q.size() + exp_qs.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
